// File: rtl/reg_f_mp_if.sv
// Bus bundle for reg_f_mp: write/read controls, external IO lanes and status.
interface reg_f_mp_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 8,
  parameter int unsigned NPORT = 2
);
  localparam int unsigned ADDR_W = (SIZE + NPORT > 1) ? $clog2(SIZE + NPORT) : 1;

  logic [WIDTH-1:0]       IN;
  logic                   EN;
  logic [ADDR_W-1:0]      WSEL;
  logic [ADDR_W-1:0]      RSEL_A;
  logic [ADDR_W-1:0]      RSEL_B;
  logic [NPORT*WIDTH-1:0] PORT_IN;
  logic [NPORT*WIDTH-1:0] PORT_OUT;
  logic [WIDTH-1:0]       OUT_A;
  logic [WIDTH-1:0]       OUT_B;
  logic [NPORT-1:0]       PORT_EVT;
  logic                   ERR;

  modport master (
    output IN, EN, WSEL, RSEL_A, RSEL_B, PORT_IN,
    input  PORT_OUT, OUT_A, OUT_B, PORT_EVT, ERR
  );

  modport slave (
    input  IN, EN, WSEL, RSEL_A, RSEL_B, PORT_IN,
    output PORT_OUT, OUT_A, OUT_B, PORT_EVT, ERR
  );
endinterface

// File: rtl/reg_f_mp.sv
// Dual-read register file with memory-mapped IO lanes: synchronised inputs with
// sticky change flags, latched outputs, and a registered address-error pulse.
module reg_f_mp #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SIZE        = 8,
  parameter int unsigned NPORT       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ZERO_R0     = 1'b0
) (
  input logic          CLK,
  input logic          RST_N,
  reg_f_mp_if.slave    bus
);
  localparam int unsigned NADDR = SIZE + NPORT;
  localparam int unsigned LAST  = SYNC_STAGES - 1;

  logic [WIDTH-1:0]       regs   [SIZE];
  logic [WIDTH-1:0]       sync_q [NPORT][SYNC_STAGES];
  logic [WIDTH-1:0]       prev_q [NPORT];
  logic [NPORT*WIDTH-1:0] port_out_q;
  logic [NPORT-1:0]       evt_q;
  logic [WIDTH-1:0]       out_a_q;
  logic [WIDTH-1:0]       out_b_q;
  logic                   err_q;

  int unsigned      wsel_i;
  int unsigned      rsel_a_i;
  int unsigned      rsel_b_i;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [NPORT-1:0] evt_set;
  logic [NPORT-1:0] evt_clr;
  logic             err_next;

  assign wsel_i   = 32'(bus.WSEL);
  assign rsel_a_i = 32'(bus.RSEL_A);
  assign rsel_b_i = 32'(bus.RSEL_B);

  // Read mux: general registers with write-first bypass, then synchronised
  // lanes; unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned r = 0; r < SIZE; r++) begin
      if (rsel_a_i == r) rd_a = (bus.EN && wsel_i == r) ? bus.IN : regs[r];
      if (rsel_b_i == r) rd_b = (bus.EN && wsel_i == r) ? bus.IN : regs[r];
    end
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (rsel_a_i == SIZE + i) rd_a = sync_q[i][LAST];
      if (rsel_b_i == SIZE + i) rd_b = sync_q[i][LAST];
    end
    if (ZERO_R0 && rsel_a_i == 0) rd_a = '0;
    if (ZERO_R0 && rsel_b_i == 0) rd_b = '0;
  end

  always_comb begin
    evt_set = '0;
    evt_clr = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      evt_set[i] = (sync_q[i][LAST] != prev_q[i]);
      evt_clr[i] = (rsel_a_i == SIZE + i) || (rsel_b_i == SIZE + i);
    end
    err_next = (bus.EN && wsel_i >= NADDR) || (rsel_a_i >= NADDR) || (rsel_b_i >= NADDR);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned r = 0; r < SIZE; r++) regs[r] <= '0;
      for (int unsigned i = 0; i < NPORT; i++) begin
        prev_q[i] <= '0;
        for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[i][s] <= '0;
      end
      port_out_q <= '0;
      evt_q      <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      err_q      <= '0;
    end else begin
      for (int unsigned r = 0; r < SIZE; r++) begin
        if (bus.EN && wsel_i == r && !(ZERO_R0 && r == 0)) regs[r] <= bus.IN;
      end
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (bus.EN && wsel_i == SIZE + i) port_out_q[i*WIDTH +: WIDTH] <= bus.IN;
        sync_q[i][0] <= bus.PORT_IN[i*WIDTH +: WIDTH];
        for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[i][s] <= sync_q[i][s-1];
        prev_q[i] <= sync_q[i][LAST];
      end
      // Set takes priority over a read-clear landing on the same edge.
      evt_q   <= (evt_q & ~evt_clr) | evt_set;
      out_a_q <= rd_a;
      out_b_q <= rd_b;
      err_q   <= err_next;
    end
  end

  assign bus.PORT_OUT = port_out_q;
  assign bus.PORT_EVT = evt_q;
  assign bus.OUT_A    = out_a_q;
  assign bus.OUT_B    = out_b_q;
  assign bus.ERR      = err_q;
endmodule

// File: tb/tb_reg_f_mp.sv
// Directed bench for reg_f_mp: default instance plus an NPORT=3, ZERO_R0=1 instance.
module tb_reg_f_mp;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  reg_f_mp_if #(.WIDTH(8), .SIZE(8), .NPORT(2)) ifa ();
  reg_f_mp_if #(.WIDTH(8), .SIZE(8), .NPORT(3)) ifb ();

  reg_f_mp #(.WIDTH(8), .SIZE(8), .NPORT(2), .SYNC_STAGES(2), .ZERO_R0(0))
    dut_a (.CLK(clk), .RST_N(rst_n), .bus(ifa));
  reg_f_mp #(.WIDTH(8), .SIZE(8), .NPORT(3), .SYNC_STAGES(2), .ZERO_R0(1))
    dut_b (.CLK(clk), .RST_N(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.EN = 1'b0; ifa.WSEL = '0; ifa.IN = '0; ifa.RSEL_A = '0; ifa.RSEL_B = '0;
  endtask

  task automatic idle_b();
    ifb.EN = 1'b0; ifb.WSEL = '0; ifb.IN = '0; ifb.RSEL_A = '0; ifb.RSEL_B = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.EN = 1'b1; ifa.WSEL = 4'd3; ifa.IN = 8'h77; ifa.RSEL_A = 4'd3; ifa.RSEL_B = 4'd9;
    ifa.PORT_IN = '0;
    ifb.EN = 1'b1; ifb.WSEL = 4'd9; ifb.IN = 8'h66; ifb.RSEL_A = 4'd15; ifb.RSEL_B = 4'd0;
    ifb.PORT_IN = '0;
    tick(); tick();
    n_cmp++; if (ifa.OUT_A !== 8'h00) begin n_bad++; $display("FAIL rst_out_a: got %h want 00", ifa.OUT_A); end
    n_cmp++; if (ifa.OUT_B !== 8'h00) begin n_bad++; $display("FAIL rst_out_b: got %h want 00", ifa.OUT_B); end
    n_cmp++; if (ifa.PORT_OUT !== 16'h0000) begin n_bad++; $display("FAIL rst_port_out: got %h want 0000", ifa.PORT_OUT); end
    n_cmp++; if (ifa.PORT_EVT !== 2'b00) begin n_bad++; $display("FAIL rst_evt: got %b want 00", ifa.PORT_EVT); end
    n_cmp++; if (ifa.ERR !== 1'b0) begin n_bad++; $display("FAIL rst_err_a: got %b want 0", ifa.ERR); end
    n_cmp++; if (ifb.ERR !== 1'b0) begin n_bad++; $display("FAIL rst_err_b: got %b want 0", ifb.ERR); end
    n_cmp++; if (ifb.PORT_OUT !== 24'h000000) begin n_bad++; $display("FAIL rst_port_out_b: got %h want 000000", ifb.PORT_OUT); end
    rst_n = 1'b1;
    idle_a(); idle_b();
    ifa.RSEL_A = 4'd3;
    tick();
    n_cmp++; if (ifa.OUT_A !== 8'h00) begin n_bad++; $display("FAIL rst_no_write: got %h want 00", ifa.OUT_A); end
  endtask

  task automatic test_write_read();
    logic [7:0] tbl [8];
    tbl = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};
    idle_a();
    ifa.EN = 1'b1; ifa.WSEL = 4'd3; ifa.IN = 8'hA5; ifa.RSEL_B = 4'd4;
    tick();
    ifa.EN = 1'b0; ifa.RSEL_A = 4'd3; ifa.RSEL_B = 4'd4;
    tick();
    n_cmp++; if (ifa.OUT_A !== 8'hA5) begin n_bad++; $display("FAIL wr_rd_a: got %h want a5", ifa.OUT_A); end
    n_cmp++; if (ifa.OUT_B !== 8'h00) begin n_bad++; $display("FAIL wr_rd_b: got %h want 00", ifa.OUT_B); end
    for (int r = 0; r < 8; r++) begin
      ifa.EN = 1'b1; ifa.WSEL = 4'(r); ifa.IN = tbl[r]; ifa.RSEL_A = 4'd9; ifa.RSEL_B = 4'd9;
      tick();
    end
    ifa.EN = 1'b0;
    for (int r = 0; r < 8; r++) begin
      ifa.RSEL_A = 4'(r); ifa.RSEL_B = 4'(7 - r);
      tick();
      n_cmp++; if (ifa.OUT_A !== tbl[r]) begin n_bad++; $display("FAIL fill_a[%0d]: got %h want %h", r, ifa.OUT_A, tbl[r]); end
      n_cmp++; if (ifa.OUT_B !== tbl[7-r]) begin n_bad++; $display("FAIL fill_b[%0d]: got %h want %h", r, ifa.OUT_B, tbl[7-r]); end
    end
  endtask

  task automatic test_bypass();
    idle_a();
    ifa.EN = 1'b1; ifa.WSEL = 4'd5; ifa.IN = 8'h3C; ifa.RSEL_A = 4'd5; ifa.RSEL_B = 4'd5;
    tick();
    n_cmp++; if (ifa.OUT_A !== 8'h3C) begin n_bad++; $display("FAIL bypass_a: got %h want 3c", ifa.OUT_A); end
    n_cmp++; if (ifa.OUT_B !== 8'h3C) begin n_bad++; $display("FAIL bypass_b: got %h want 3c", ifa.OUT_B); end
    ifa.WSEL = 4'd6; ifa.IN = 8'h99; ifa.RSEL_B = 4'd6;
    tick();
    n_cmp++; if (ifa.OUT_A !== 8'h3C) begin n_bad++; $display("FAIL bypass_other: got %h want 3c", ifa.OUT_A); end
    n_cmp++; if (ifa.OUT_B !== 8'h99) begin n_bad++; $display("FAIL bypass_6: got %h want 99", ifa.OUT_B); end
  endtask

  task automatic test_port_out();
    idle_a();
    ifa.PORT_IN = 16'h4200;
    tick(); tick(); tick(); tick();
    n_cmp++; if (ifa.PORT_EVT !== 2'b10) begin n_bad++; $display("FAIL evt_lane1: got %b want 10", ifa.PORT_EVT); end
    ifa.EN = 1'b1; ifa.WSEL = 4'd9; ifa.IN = 8'h81;
    tick();
    n_cmp++; if (ifa.PORT_OUT !== 16'h8100) begin n_bad++; $display("FAIL port_out_l1: got %h want 8100", ifa.PORT_OUT); end
    ifa.EN = 1'b0; ifa.RSEL_A = 4'd9;
    tick();
    n_cmp++; if (ifa.OUT_A !== 8'h42) begin n_bad++; $display("FAIL port_read_l1: got %h want 42", ifa.OUT_A); end
    n_cmp++; if (ifa.PORT_EVT !== 2'b00) begin n_bad++; $display("FAIL evt_clr_l1: got %b want 00", ifa.PORT_EVT); end
    ifa.EN = 1'b1; ifa.WSEL = 4'd8; ifa.IN = 8'h5A; ifa.RSEL_A = 4'd0;
    tick();
    n_cmp++; if (ifa.PORT_OUT !== 16'h815A) begin n_bad++; $display("FAIL port_out_l0: got %h want 815a", ifa.PORT_OUT); end
    idle_a();
  endtask

  task automatic test_sync_evt();
    idle_a();
    ifa.PORT_IN = 16'h4255;
    tick(); tick();
    n_cmp++; if (ifa.PORT_EVT !== 2'b00) begin n_bad++; $display("FAIL evt_early: got %b want 00", ifa.PORT_EVT); end
    ifa.RSEL_A = 4'd8;
    tick();
    n_cmp++; if (ifa.OUT_A !== 8'h55) begin n_bad++; $display("FAIL sync_read: got %h want 55", ifa.OUT_A); end
    n_cmp++; if (ifa.PORT_EVT !== 2'b01) begin n_bad++; $display("FAIL evt_set_wins: got %b want 01", ifa.PORT_EVT); end
    tick();
    n_cmp++; if (ifa.PORT_EVT !== 2'b00) begin n_bad++; $display("FAIL evt_read_clr: got %b want 00", ifa.PORT_EVT); end
    ifa.PORT_IN = 16'h42AA; ifa.RSEL_A = 4'd0;
    tick(); tick();
    ifa.RSEL_B = 4'd8;
    tick();
    n_cmp++; if (ifa.PORT_EVT !== 2'b01) begin n_bad++; $display("FAIL evt_coincide: got %b want 01", ifa.PORT_EVT); end
    n_cmp++; if (ifa.OUT_B !== 8'hAA) begin n_bad++; $display("FAIL sync_read_b: got %h want aa", ifa.OUT_B); end
    ifa.RSEL_B = 4'd0;
    tick();
    n_cmp++; if (ifa.PORT_EVT !== 2'b01) begin n_bad++; $display("FAIL evt_sticky: got %b want 01", ifa.PORT_EVT); end
    ifa.RSEL_A = 4'd8;
    tick();
    n_cmp++; if (ifa.PORT_EVT !== 2'b00) begin n_bad++; $display("FAIL evt_clr_a: got %b want 00", ifa.PORT_EVT); end
    idle_a();
  endtask

  task automatic test_err();
    idle_b();
    ifb.EN = 1'b1; ifb.WSEL = 4'd2; ifb.IN = 8'h33;
    tick();
    ifb.EN = 1'b0; ifb.RSEL_B = 4'd12;
    tick();
    n_cmp++; if (ifb.OUT_B !== 8'h00) begin n_bad++; $display("FAIL oor_read: got %h want 00", ifb.OUT_B); end
    n_cmp++; if (ifb.ERR !== 1'b1) begin n_bad++; $display("FAIL err_read: got %b want 1", ifb.ERR); end
    ifb.RSEL_B = 4'd0;
    tick();
    n_cmp++; if (ifb.ERR !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %b want 0", ifb.ERR); end
    ifb.EN = 1'b1; ifb.WSEL = 4'd15; ifb.IN = 8'hEE;
    tick();
    n_cmp++; if (ifb.ERR !== 1'b1) begin n_bad++; $display("FAIL err_write: got %b want 1", ifb.ERR); end
    n_cmp++; if (ifb.PORT_OUT !== 24'h000000) begin n_bad++; $display("FAIL oor_write_port: got %h want 000000", ifb.PORT_OUT); end
    ifb.EN = 1'b0; ifb.RSEL_A = 4'd2; ifb.RSEL_B = 4'd10;
    tick();
    n_cmp++; if (ifb.ERR !== 1'b0) begin n_bad++; $display("FAIL err_top_addr: got %b want 0", ifb.ERR); end
    n_cmp++; if (ifb.OUT_A !== 8'h33) begin n_bad++; $display("FAIL oor_no_change: got %h want 33", ifb.OUT_A); end
    n_cmp++; if (ifb.OUT_B !== 8'h00) begin n_bad++; $display("FAIL lane2_read: got %h want 00", ifb.OUT_B); end
    idle_b();
    idle_a();
    ifa.RSEL_A = 4'd10;
    tick();
    n_cmp++; if (ifa.ERR !== 1'b1) begin n_bad++; $display("FAIL err_a_edge: got %b want 1", ifa.ERR); end
    n_cmp++; if (ifa.OUT_A !== 8'h00) begin n_bad++; $display("FAIL oor_a_edge: got %h want 00", ifa.OUT_A); end
    idle_a();
    tick();
    n_cmp++; if (ifa.ERR !== 1'b0) begin n_bad++; $display("FAIL err_a_clear: got %b want 0", ifa.ERR); end
  endtask

  task automatic test_zero_r0();
    idle_b();
    ifb.EN = 1'b1; ifb.WSEL = 4'd0; ifb.IN = 8'hFF; ifb.RSEL_A = 4'd0;
    tick();
    n_cmp++; if (ifb.OUT_A !== 8'h00) begin n_bad++; $display("FAIL r0_bypass: got %h want 00", ifb.OUT_A); end
    ifb.EN = 1'b0;
    tick();
    n_cmp++; if (ifb.OUT_A !== 8'h00) begin n_bad++; $display("FAIL r0_stored: got %h want 00", ifb.OUT_A); end
    ifb.EN = 1'b1; ifb.WSEL = 4'd8; ifb.IN = 8'h11;
    tick();
    n_cmp++; if (ifb.PORT_OUT !== 24'h000011) begin n_bad++; $display("FAIL port_out_b: got %h want 000011", ifb.PORT_OUT); end
    rst_n = 1'b0;
    ifb.EN = 1'b1; ifb.WSEL = 4'd2; ifb.IN = 8'h77; ifb.RSEL_A = 4'd2; ifb.RSEL_B = 4'd12;
    tick();
    n_cmp++; if (ifb.OUT_A !== 8'h00) begin n_bad++; $display("FAIL rstw_out_a: got %h want 00", ifb.OUT_A); end
    n_cmp++; if (ifb.OUT_B !== 8'h00) begin n_bad++; $display("FAIL rstw_out_b: got %h want 00", ifb.OUT_B); end
    n_cmp++; if (ifb.ERR !== 1'b0) begin n_bad++; $display("FAIL rstw_err: got %b want 0", ifb.ERR); end
    n_cmp++; if (ifb.PORT_OUT !== 24'h000000) begin n_bad++; $display("FAIL rstw_port_out: got %h want 000000", ifb.PORT_OUT); end
    rst_n = 1'b1;
    ifb.EN = 1'b0; ifb.RSEL_B = 4'd0;
    tick();
    n_cmp++; if (ifb.OUT_A !== 8'h00) begin n_bad++; $display("FAIL rstw_reg2: got %h want 00", ifb.OUT_A); end
    idle_b();
  endtask

  task automatic test_reset_evt();
    idle_a();
    ifa.PORT_IN = 16'h0001;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (ifa.PORT_EVT !== 2'b00) begin n_bad++; $display("FAIL rel_evt_rst: got %b want 00", ifa.PORT_EVT); end
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++; if (ifa.PORT_EVT !== 2'b00) begin n_bad++; $display("FAIL rel_evt_2: got %b want 00", ifa.PORT_EVT); end
    tick();
    n_cmp++; if (ifa.PORT_EVT !== 2'b01) begin n_bad++; $display("FAIL rel_evt_3: got %b want 01", ifa.PORT_EVT); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_port_out();
    test_sync_evt();
    test_err();
    test_zero_r0();
    test_reset_evt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_f_mp.md
REG_F_MP -- requirements
Module: reg_f_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of every register, port and bus.
REQ-002 SHALL have parameter SIZE, default 8: number of general registers, addresses 0..SIZE-1.
REQ-003 SHALL have parameter NPORT, default 2: number of IO ports, addresses SIZE..SIZE+NPORT-1.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, min 1: flop stages on each PORT_IN lane.
REQ-005 SHALL have parameter ZERO_R0, default 0: when 1, address 0 reads 0 and ignores writes.
REQ-006 SHALL derive local ADDR_W = $clog2(SIZE+NPORT), min 1.
REQ-007 SHALL have ports: CLK  in  1  sole clock, all state updates on rising edge.
REQ-008 RST_N  in  1  synchronous active-low reset.
REQ-009 IN  in  WIDTH  write data.
REQ-010 EN  in  1  write enable.
REQ-011 WSEL  in  ADDR_W  write address.
REQ-012 RSEL_A / RSEL_B  in  ADDR_W each  read addresses, ports A and B.
REQ-013 PORT_IN  in  NPORT*WIDTH  external inputs, lane i = bits [i*WIDTH +: WIDTH], asynchronous to CLK.
REQ-014 PORT_OUT  out  NPORT*WIDTH  registered output latches, same lane packing.
REQ-015 OUT_A / OUT_B  out  WIDTH each  registered read data.
REQ-016 PORT_EVT  out  NPORT  sticky per-lane input-change flags.
REQ-017 ERR  out  1  registered address-error pulse.

Function
REQ-018 Reads SHALL have 1-cycle latency: OUT_x after edge k reflects RSEL_x sampled at edge k.
REQ-019 General address read SHALL return stored value; if EN=1 and WSEL==RSEL_x same cycle, SHALL return IN (write-first bypass), except address 0 with ZERO_R0=1 returns 0.
REQ-020 EN=1, WSEL<SIZE SHALL store IN at WSEL on the edge (ignored for address 0 when ZERO_R0=1).
REQ-021 EN=1, WSEL=SIZE+i SHALL load IN into PORT_OUT lane i; no bypass, lane not readable.
REQ-022 Read of SIZE+i SHALL return synchronised lane i (final sync stage value before the edge), never PORT_OUT.
REQ-023 Each lane SHALL pass through SYNC_STAGES flops; PORT_IN change visible to reads after SYNC_STAGES edges.
REQ-024 PORT_EVT[i] SHALL set on edge where final sync stage differs from its previous-cycle value.
REQ-025 PORT_EVT[i] SHALL clear on edge where RSEL_A or RSEL_B == SIZE+i; set and clear same edge -> set wins.
REQ-026 Out-of-range address (>= SIZE+NPORT): write ignored, read returns 0.
REQ-027 ERR SHALL be 1 for exactly the cycle after any edge sampling (EN=1 and WSEL out of range) or RSEL_A/RSEL_B out of range; else 0.
REQ-028 Both read ports SHALL be independent; RSEL_A==RSEL_B SHALL return identical data.

Reset
REQ-029 RST_N=0 at an edge SHALL zero all general registers, PORT_OUT, OUT_A, OUT_B, all sync stages, previous-value regs, PORT_EVT, ERR.
REQ-030 Reset SHALL override EN, reads and event set in the same cycle.
REQ-031 After reset release, nonzero PORT_IN SHALL raise PORT_EVT after SYNC_STAGES+1 edges (sync chain starts at 0).

Verification
REQ-032 Reset, EN=1 WSEL=3 IN=0xA5; next cycle RSEL_A=3 -> OUT_A=0xA5 one edge later, OUT_B=0 for RSEL_B=4.
REQ-033 EN=1 WSEL=5 IN=0x3C with RSEL_A=5 same cycle -> OUT_A=0x3C after that edge (bypass).
REQ-034 EN=1 WSEL=SIZE+1 IN=0x81 -> PORT_OUT lane 1=0x81, lane 0 unchanged 0; RSEL_A=SIZE+1 returns sync'd PORT_IN lane 1, not 0x81.
REQ-035 PORT_IN lane 0 0x00->0x55 (SYNC_STAGES=2) -> read of SIZE shows 0x55 after 2 edges, PORT_EVT[0]=1 after 3; read SIZE clears it; change coinciding with clear keeps it 1.
REQ-036 SIZE=8 NPORT=3 ADDR_W=4: RSEL_B=12 -> OUT_B=0, ERR=1 one cycle; EN=1 WSEL=15 -> no state change, ERR=1.
REQ-037 ZERO_R0=1: write 0xFF to 0 -> read 0 = 0; RST_N=0 mid-write to 2 -> register 2 stays 0, all outputs 0.
